mem64_arbiter: RTL and testbench

MEM64_ARBITER -- requirements
Module: mem64_arbiter

---
 rtl/mem64_arbiter_if.sv | 38 +++
 rtl/mem64_arbiter.sv | 102 ++++++++++
 tb/tb_mem64_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem64_arbiter_if.sv
// rtl/mem64_arbiter_if.sv - requester, clear and memory-side signals of the two-port arbiter
interface mem64_arbiter_if;
  logic       REQ_A;
  logic       REQ_B;
  logic       WE_A;
  logic       WE_B;
  logic [5:0] ADDR_A;
  logic [5:0] ADDR_B;
  logic [7:0] DIN_A;
  logic [7:0] DIN_B;
  logic       CLR_REQ;
  logic       GNT_A;
  logic       GNT_B;
  logic       ACK_A;
  logic       ACK_B;
  logic [7:0] DOUT_A;
  logic [7:0] DOUT_B;
  logic       CLR_ACK;
  logic       BUSY;
  logic [7:0] M_DIN;
  logic [5:0] M_ADDR;
  logic       M_R_EN;
  logic       M_W_EN;
  logic       M_RESET;
  logic [7:0] M_DOUT;

  modport slave (
    input  REQ_A, REQ_B, WE_A, WE_B, ADDR_A, ADDR_B, DIN_A, DIN_B, CLR_REQ, M_DOUT,
    output GNT_A, GNT_B, ACK_A, ACK_B, DOUT_A, DOUT_B, CLR_ACK, BUSY,
           M_DIN, M_ADDR, M_R_EN, M_W_EN, M_RESET
  );

  modport master (
    output REQ_A, REQ_B, WE_A, WE_B, ADDR_A, ADDR_B, DIN_A, DIN_B, CLR_REQ, M_DOUT,
    input  GNT_A, GNT_B, ACK_A, ACK_B, DOUT_A, DOUT_B, CLR_ACK, BUSY,
           M_DIN, M_ADDR, M_R_EN, M_W_EN, M_RESET
  );
endinterface

// File: rtl/mem64_arbiter.sv
// rtl/mem64_arbiter.sv - round-robin two-requester arbiter for a 64x8 memory with whole-memory clear
module mem64_arbiter (
  input  logic           CLK,
  input  logic           RESET,
  mem64_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ACCESS, WAIT, DONE, CLEAR} state_t;

  state_t     state;
  state_t     state_n;
  logic       pri;
  logic       winner;
  logic       winner_n;
  logic       we_l;
  logic       we_n;
  logic       clr_op;
  logic       clr_n;
  logic       start;
  logic       owns_n;
  logic [5:0] sel_addr;
  logic [7:0] sel_din;

  always_ff @(posedge CLK) begin
    if (!RESET) state <= IDLE;
    else        state <= state_n;
  end

  // Outputs are derived from the next state so that every output is a register.
  always_comb begin
    state_n  = state;
    winner_n = winner;
    clr_n    = clr_op;
    start    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.CLR_REQ) begin
          state_n = CLEAR;
          clr_n   = 1'b1;
        end else if (bus.REQ_A || bus.REQ_B) begin
          state_n  = ACCESS;
          start    = 1'b1;
          clr_n    = 1'b0;
          winner_n = (bus.REQ_A && bus.REQ_B) ? pri : bus.REQ_B;
        end
      end
      ACCESS:  state_n = WAIT;
      WAIT:    state_n = DONE;
      DONE:    state_n = IDLE;
      CLEAR:   state_n = DONE;
      default: state_n = IDLE;
    endcase
    sel_addr = winner_n ? bus.ADDR_B : bus.ADDR_A;
    sel_din  = winner_n ? bus.DIN_B  : bus.DIN_A;
    we_n     = start ? (winner_n ? bus.WE_B : bus.WE_A) : we_l;
    owns_n   = !clr_n && (state_n == ACCESS || state_n == WAIT || state_n == DONE);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      pri         <= 1'b0;
      winner      <= 1'b0;
      we_l        <= 1'b0;
      clr_op      <= 1'b0;
      bus.GNT_A   <= 1'b0;
      bus.GNT_B   <= 1'b0;
      bus.ACK_A   <= 1'b0;
      bus.ACK_B   <= 1'b0;
      bus.CLR_ACK <= 1'b0;
      bus.BUSY    <= 1'b0;
      bus.M_R_EN  <= 1'b0;
      bus.M_W_EN  <= 1'b0;
      bus.M_RESET <= 1'b0;
      bus.M_ADDR  <= 6'd0;
      bus.M_DIN   <= 8'd0;
      bus.DOUT_A  <= 8'd0;
      bus.DOUT_B  <= 8'd0;
    end else begin
      winner <= winner_n;
      we_l   <= we_n;
      clr_op <= clr_n;
      if (start) begin
        bus.M_ADDR <= sel_addr;
        bus.M_DIN  <= sel_din;
      end
      // The loser of this transaction is favoured next time; a clear leaves PRI alone.
      if (state == DONE && !clr_op) pri <= ~winner;
      if (state == WAIT && !we_l) begin
        if (winner) bus.DOUT_B <= bus.M_DOUT;
        else        bus.DOUT_A <= bus.M_DOUT;
      end
      bus.GNT_A   <= owns_n && !winner_n;
      bus.GNT_B   <= owns_n && winner_n;
      bus.ACK_A   <= (state_n == DONE) && !clr_n && !winner_n;
      bus.ACK_B   <= (state_n == DONE) && !clr_n && winner_n;
      bus.CLR_ACK <= (state_n == DONE) && clr_n;
      bus.BUSY    <= (state_n != IDLE);
      bus.M_RESET <= (state_n == CLEAR);
      bus.M_W_EN  <= (state_n == ACCESS) && we_n;
      bus.M_R_EN  <= (state_n == ACCESS) && !we_n;
    end
  end
endmodule

// File: tb/tb_mem64_arbiter.sv
// tb/tb_mem64_arbiter.sv - randomized self-checking bench for mem64_arbiter against a transaction-level model
module tb_mem64_arbiter;
  logic CLK = 1'b0;
  logic RESET;
  logic fill;
  always #5 CLK = ~CLK;

  mem64_arbiter_if bus();
  mem64_arbiter dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 29 + 7);
  endfunction

  // Memory macro attached to the arbiter: read data valid the cycle after a read-enabled edge.
  logic [7:0] ram [64];
  always @(posedge CLK) begin
    if (fill) begin
      for (int i = 0; i < 64; i++) ram[i] <= pat(i);
    end else if (bus.M_RESET) begin
      for (int i = 0; i < 64; i++) ram[i] <= 8'h00;
    end else if (bus.M_W_EN) begin
      ram[bus.M_ADDR] <= bus.M_DIN;
    end
    if (bus.M_R_EN) bus.M_DOUT <= ram[bus.M_ADDR];
  end

  // Reference model: memory contents, per-requester last read data, last winner.
  logic [7:0] ref_mem [64];
  logic [7:0] exp_dout [2];
  int    last_win;
  int    checks = 0;
  int    errors = 0;
  string order;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [8:0] ctl_vec;
    return {bus.GNT_A, bus.GNT_B, bus.ACK_A, bus.ACK_B, bus.M_W_EN, bus.M_R_EN,
            bus.M_RESET, bus.CLR_ACK, bus.BUSY};
  endfunction

  task automatic set_req(input int side, input logic we, input logic [5:0] a, input logic [7:0] d);
    if (side == 0) begin
      bus.WE_A = we; bus.ADDR_A = a; bus.DIN_A = d; bus.REQ_A = 1'b1;
    end else begin
      bus.WE_B = we; bus.ADDR_B = a; bus.DIN_B = d; bus.REQ_B = 1'b1;
    end
  endtask

  task automatic rand_req(input int side);
    logic [5:0] a;
    a = ($urandom_range(1, 0) == 1) ? 6'($urandom_range(7, 0)) : 6'($urandom_range(63, 0));
    set_req(side, 1'($urandom_range(1, 0)), a, 8'($urandom));
  endtask

  task automatic drop_all;
    bus.REQ_A = 1'b0;
    bus.REQ_B = 1'b0;
  endtask

  task automatic do_reset(input bit refill);
    RESET = 1'b0;
    fill  = refill;
    tick;
    fill  = 1'b0;
    tick;
    if (refill) for (int i = 0; i < 64; i++) ref_mem[i] = pat(i);
    exp_dout[0] = 8'h00;
    exp_dout[1] = 8'h00;
    last_win    = 1;
  endtask

  // Serves n transactions from the current requests. mode 0: winner drops its request,
  // 1: winner re-requests at once, 2: random mix. scramble perturbs the winner's inputs after grant.
  task automatic serve(input int n, input int mode, input bit scramble);
    for (int t = 0; t < n; t++) begin
      int         w;
      logic       we;
      logic [5:0] a;
      logic [7:0] d;
      w  = (bus.REQ_A && bus.REQ_B) ? ((last_win == 0) ? 1 : 0) : (bus.REQ_B ? 1 : 0);
      we = (w == 1) ? bus.WE_B   : bus.WE_A;
      a  = (w == 1) ? bus.ADDR_B : bus.ADDR_A;
      d  = (w == 1) ? bus.DIN_B  : bus.DIN_A;
      tick;
      checks++;
      if (ctl_vec() !== {w == 0, w == 1, 2'b00, we, !we, 3'b001}) begin
        errors++; $display("FAIL access_ctl txn %0d got %b want %b", t, ctl_vec(), {w == 0, w == 1, 2'b00, we, !we, 3'b001});
      end
      checks++;
      if (bus.M_ADDR !== a || (we && bus.M_DIN !== d)) begin
        errors++; $display("FAIL access_addr txn %0d got %h/%h want %h/%h", t, bus.M_ADDR, bus.M_DIN, a, d);
      end
      if (scramble) begin
        if (w == 1) begin bus.WE_B = ~bus.WE_B; bus.ADDR_B = 6'($urandom); bus.DIN_B = 8'($urandom); end
        else        begin bus.WE_A = ~bus.WE_A; bus.ADDR_A = 6'($urandom); bus.DIN_A = 8'($urandom); end
      end
      tick;
      checks++;
      if (ctl_vec() !== {w == 0, w == 1, 7'b0000001}) begin
        errors++; $display("FAIL wait_ctl txn %0d got %b want %b", t, ctl_vec(), {w == 0, w == 1, 7'b0000001});
      end
      tick;
      if (we) ref_mem[a] = d;
      else    exp_dout[w] = ref_mem[a];
      checks++;
      if (ctl_vec() !== {w == 0, w == 1, w == 0, w == 1, 5'b00001}) begin
        errors++; $display("FAIL done_ctl txn %0d got %b want %b", t, ctl_vec(), {w == 0, w == 1, w == 0, w == 1, 5'b00001});
      end
      checks++;
      if (bus.DOUT_A !== exp_dout[0] || bus.DOUT_B !== exp_dout[1]) begin
        errors++; $display("FAIL dout txn %0d got %h/%h want %h/%h", t, bus.DOUT_A, bus.DOUT_B, exp_dout[0], exp_dout[1]);
      end
      last_win = w;
      order = {order, (w == 1) ? "B" : "A"};
      if (mode == 1) rand_req(w);
      else if (mode == 2 && $urandom_range(1, 0) == 1) rand_req(w);
      else if (w == 1) bus.REQ_B = 1'b0;
      else bus.REQ_A = 1'b0;
      if (mode == 2) begin
        if ($urandom_range(1, 0) == 1) begin
          if (w == 1 && !bus.REQ_A) rand_req(0);
          if (w == 0 && !bus.REQ_B) rand_req(1);
        end
        if (!bus.REQ_A && !bus.REQ_B) rand_req(int'($urandom_range(1, 0)));
      end
      tick;
      checks++;
      if (ctl_vec() !== 9'b0) begin
        errors++; $display("FAIL idle_ctl txn %0d got %b want 0", t, ctl_vec());
      end
    end
  endtask

  task automatic test_reset;
    set_req(0, 1'b1, 6'd9, 8'h5A);
    do_reset(1);
    checks++;
    if (ctl_vec() !== 9'b0) begin errors++; $display("FAIL reset_ctl got %b want 0", ctl_vec()); end
    checks++;
    if (bus.M_ADDR !== 6'd0 || bus.M_DIN !== 8'd0) begin
      errors++; $display("FAIL reset_mbus got %h/%h want 0/0", bus.M_ADDR, bus.M_DIN);
    end
    checks++;
    if (bus.DOUT_A !== 8'd0 || bus.DOUT_B !== 8'd0) begin
      errors++; $display("FAIL reset_dout got %h/%h want 0/0", bus.DOUT_A, bus.DOUT_B);
    end
    drop_all;
    RESET = 1'b1;
    tick;
    checks++;
    if (ctl_vec() !== 9'b0) begin errors++; $display("FAIL reset_idle got %b want 0", ctl_vec()); end
  endtask

  task automatic test_write_read;
    set_req(0, 1'b1, 6'd0, 8'h01);
    serve(1, 0, 1'b0);
    set_req(0, 1'b0, 6'd0, 8'h00);
    serve(1, 0, 1'b0);
    checks++;
    if (bus.DOUT_A !== 8'h01) begin errors++; $display("FAIL write_read got %h want 01", bus.DOUT_A); end
    set_req(1, 1'b1, 6'd63, 8'hFF);
    serve(1, 0, 1'b0);
    set_req(1, 1'b0, 6'd63, 8'h00);
    serve(1, 0, 1'b0);
    checks++;
    if (bus.DOUT_B !== 8'hFF || bus.DOUT_A !== 8'h01) begin
      errors++; $display("FAIL top_addr got %h/%h want 01/ff", bus.DOUT_A, bus.DOUT_B);
    end
  endtask

  task automatic test_simultaneous;
    do_reset(0);
    RESET = 1'b1;
    set_req(0, 1'b1, 6'd50, 8'h02);
    set_req(1, 1'b0, 6'd50, 8'h00);
    order = "";
    serve(2, 0, 1'b0);
    checks++;
    if (order != "AB" || bus.DOUT_B !== 8'h02) begin
      errors++; $display("FAIL simultaneous got %s/%h want AB/02", order, bus.DOUT_B);
    end
  endtask

  task automatic test_fairness;
    do_reset(0);
    RESET = 1'b1;
    rand_req(0);
    rand_req(1);
    order = "";
    serve(6, 1, 1'b0);
    drop_all;
    checks++;
    if (order != "ABABAB") begin errors++; $display("FAIL fairness got %s want ABABAB", order); end
  endtask

  task automatic test_stability;
    set_req(0, 1'b1, 6'd10, 8'h3C);
    serve(1, 0, 1'b1);
    set_req(0, 1'b0, 6'd10, 8'h00);
    serve(1, 0, 1'b0);
    checks++;
    if (bus.DOUT_A !== 8'h3C) begin errors++; $display("FAIL stability got %h want 3c", bus.DOUT_A); end
  endtask

  task automatic test_midop_reset;
    set_req(0, 1'b1, 6'd5, 8'hA5);
    serve(1, 0, 1'b0);
    set_req(0, 1'b0, 6'd5, 8'h00);
    serve(1, 0, 1'b0);
    set_req(1, 1'b0, 6'd5, 8'h00);
    tick;
    tick;
    checks++;
    if (ctl_vec() !== 9'b010000001) begin errors++; $display("FAIL midop_wait got %b want 010000001", ctl_vec()); end
    RESET = 1'b0;
    tick;
    checks++;
    if (ctl_vec() !== 9'b0 || bus.DOUT_A !== 8'd0 || bus.DOUT_B !== 8'd0 || bus.M_ADDR !== 6'd0) begin
      errors++; $display("FAIL midop_reset got %b %h/%h/%h want all 0", ctl_vec(), bus.DOUT_A, bus.DOUT_B, bus.M_ADDR);
    end
    exp_dout[0] = 8'h00;
    exp_dout[1] = 8'h00;
    last_win    = 1;
    bus.REQ_B = 1'b0;
    RESET = 1'b1;
    tick;
    rand_req(0);
    rand_req(1);
    order = "";
    serve(2, 0, 1'b0);
    checks++;
    if (order != "AB") begin errors++; $display("FAIL midop_pri got %s want AB", order); end
  endtask

  task automatic test_clear;
    bus.WE_B = 1'b1; bus.ADDR_B = 6'd50; bus.DIN_B = 8'h77; bus.REQ_B = 1'b1;
    serve(1, 0, 1'b0);
    set_req(0, 1'b0, 6'd50, 8'h00);
    bus.CLR_REQ = 1'b1;
    tick;
    bus.CLR_REQ = 1'b0;
    checks++;
    if (ctl_vec() !== 9'b000000101) begin errors++; $display("FAIL clear_reset got %b want 000000101", ctl_vec()); end
    tick;
    checks++;
    if (ctl_vec() !== 9'b000000011) begin errors++; $display("FAIL clear_ack got %b want 000000011", ctl_vec()); end
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    tick;
    checks++;
    if (ctl_vec() !== 9'b0) begin errors++; $display("FAIL clear_idle got %b want 0", ctl_vec()); end
    serve(1, 0, 1'b0);
    checks++;
    if (bus.DOUT_A !== 8'h00) begin errors++; $display("FAIL clear_read got %h want 00", bus.DOUT_A); end
  endtask

  task automatic test_random;
    rand_req(0);
    if ($urandom_range(1, 0) == 1) rand_req(1);
    serve(40, 2, 1'b0);
    drop_all;
    tick;
  endtask

  initial begin
    RESET = 1'b0; fill = 1'b0;
    bus.REQ_A = 1'b0; bus.REQ_B = 1'b0; bus.WE_A = 1'b0; bus.WE_B = 1'b0;
    bus.ADDR_A = 6'd0; bus.ADDR_B = 6'd0; bus.DIN_A = 8'd0; bus.DIN_B = 8'd0;
    bus.CLR_REQ = 1'b0;
    test_reset;
    test_write_read;
    test_simultaneous;
    test_fairness;
    test_stability;
    test_midop_reset;
    test_clear;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
